// File: rtl/i2c_slave_responder.sv
// I2C target: decodes START/STOP, matches a 7-bit address, ACKs written bytes and shifts out core-supplied read bytes.
// Optional clock stretching on the read path is enabled by defining I2C_SLAVE_STRETCH_EN.
module i2c_slave_responder #(
  parameter logic [6:0] DEVICE_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       SYS_CLOCK,
  input  logic       RST_N,
  inout  wire        SDA,
  inout  wire        SCL,
  output logic [7:0] MOSI,
  output logic       MOSI_VALID,
  input  logic [7:0] MISO,
  output logic       MISO_REQ,
  input  logic       MISO_VALID,
  output logic       BUSY,
  output logic       STOP_DET
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_RD_WAIT,
    S_IGNORE
  } state_t;

  state_t            r_state;
  logic [STAGES-1:0] r_sclSync;
  logic [STAGES-1:0] r_sdaSync;
  logic              r_sclPrev;
  logic              r_sdaPrev;
  logic [6:0]        r_shift;
  logic [2:0]        r_bitCnt;
  logic              r_rw;
  logic              r_ackHeld;
  logic              r_sdaOe;

  logic       w_scl;
  logic       w_sda;
  logic       w_sclRise;
  logic       w_sclFall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;
  logic       w_addrMatch;
  logic       w_loadFall;

  always_ff @(posedge SYS_CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      r_sclSync <= '1;
      r_sdaSync <= '1;
      r_sclPrev <= 1'b1;
      r_sdaPrev <= 1'b1;
    end else begin
      r_sclSync <= {r_sclSync[STAGES-2:0], SCL};
      r_sdaSync <= {r_sdaSync[STAGES-2:0], SDA};
      r_sclPrev <= w_scl;
      r_sdaPrev <= w_sda;
    end
  end

  assign w_scl       = r_sclSync[STAGES-1];
  assign w_sda       = r_sdaSync[STAGES-1];
  assign w_sclRise   = w_scl & ~r_sclPrev;
  assign w_sclFall   = ~w_scl & r_sclPrev;
  assign w_start     = w_scl & r_sclPrev & r_sdaPrev & ~w_sda;
  assign w_stop      = w_scl & r_sclPrev & ~r_sdaPrev & w_sda;
  assign w_byte      = {r_shift, w_sda};
  assign w_addrMatch = (w_byte[7:1] == DEVICE_ADDR);

  // The SCL fall that ends an ACKed read handshake is where the next MISO byte is taken.
  assign w_loadFall = w_sclFall & r_ackHeld &
                      (((r_state == S_ADDR_ACK) & r_rw) | (r_state == S_RD_ACK));

`ifdef I2C_SLAVE_STRETCH_EN
  logic r_sclOe;
  assign SCL = r_sclOe ? 1'b0 : 1'bz;
`else
  logic w_unused;
  assign w_unused = MISO_VALID;
  assign SCL      = 1'bz;
`endif

  assign SDA = r_sdaOe ? 1'b0 : 1'bz;

  always_ff @(posedge SYS_CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_rw       <= 1'b0;
      r_ackHeld  <= 1'b0;
      r_sdaOe    <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      r_sclOe    <= 1'b0;
`endif
      MOSI       <= '0;
      MOSI_VALID <= 1'b0;
      MISO_REQ   <= 1'b0;
      BUSY       <= 1'b0;
      STOP_DET   <= 1'b0;
    end else begin
      MOSI_VALID <= 1'b0;
      MISO_REQ   <= 1'b0;
      STOP_DET   <= 1'b0;
      if (w_stop) begin
        r_state   <= S_IDLE;
        r_sdaOe   <= 1'b0;
        r_ackHeld <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
        r_sclOe   <= 1'b0;
`endif
        BUSY      <= 1'b0;
        STOP_DET  <= 1'b1;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_bitCnt  <= '0;
        r_sdaOe   <= 1'b0;
        r_ackHeld <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
        r_sclOe   <= 1'b0;
`endif
      end else if (w_loadFall) begin
        r_ackHeld <= 1'b0;
        r_bitCnt  <= '0;
`ifdef I2C_SLAVE_STRETCH_EN
        if (MISO_VALID) begin
          r_shift <= MISO[6:0];
          r_sdaOe <= ~MISO[7];
          r_state <= S_RD_DATA;
        end else begin
          r_sdaOe <= 1'b0;
          r_sclOe <= 1'b1;
          r_state <= S_RD_WAIT;
        end
`else
        r_shift <= MISO[6:0];
        r_sdaOe <= ~MISO[7];
        r_state <= S_RD_DATA;
`endif
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_sclRise) begin
              r_shift  <= w_byte[6:0];
              r_bitCnt <= r_bitCnt + 3'd1;
              if (r_bitCnt == 3'd7) begin
                r_rw <= w_byte[0];
                if (w_addrMatch) begin
                  r_state <= S_ADDR_ACK;
                end else begin
                  r_state <= S_IGNORE;
                  BUSY    <= 1'b0;
                end
              end
            end
          end
          // First fall starts driving the ACK, second fall ends it; reads leave via w_loadFall.
          S_ADDR_ACK: begin
            if (w_sclFall) begin
              if (!r_ackHeld) begin
                r_sdaOe   <= 1'b1;
                r_ackHeld <= 1'b1;
                BUSY      <= 1'b1;
              end else begin
                r_sdaOe   <= 1'b0;
                r_ackHeld <= 1'b0;
                r_bitCnt  <= '0;
                r_state   <= S_WR_DATA;
              end
            end else if (w_sclRise && r_ackHeld && r_rw) begin
              MISO_REQ <= 1'b1;
            end
          end
          S_WR_DATA: begin
            if (w_sclRise) begin
              r_shift  <= w_byte[6:0];
              r_bitCnt <= r_bitCnt + 3'd1;
              if (r_bitCnt == 3'd7) begin
                MOSI       <= w_byte;
                MOSI_VALID <= 1'b1;
                r_state    <= S_WR_ACK;
              end
            end
          end
          S_WR_ACK: begin
            if (w_sclFall) begin
              if (!r_ackHeld) begin
                r_sdaOe   <= 1'b1;
                r_ackHeld <= 1'b1;
              end else begin
                r_sdaOe   <= 1'b0;
                r_ackHeld <= 1'b0;
                r_bitCnt  <= '0;
                r_state   <= S_WR_DATA;
              end
            end
          end
          S_RD_DATA: begin
            if (w_sclFall) begin
              if (r_bitCnt == 3'd7) begin
                r_sdaOe <= 1'b0;
                r_state <= S_RD_ACK;
              end else begin
                r_sdaOe  <= ~r_shift[6];
                r_shift  <= {r_shift[5:0], 1'b0};
                r_bitCnt <= r_bitCnt + 3'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (w_sclRise) begin
              if (!w_sda) begin
                MISO_REQ  <= 1'b1;
                r_ackHeld <= 1'b1;
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end
`ifdef I2C_SLAVE_STRETCH_EN
          S_RD_WAIT: begin
            if (MISO_VALID) begin
              r_shift <= MISO[6:0];
              r_sdaOe <= ~MISO[7];
              r_sclOe <= 1'b0;
              r_state <= S_RD_DATA;
            end
          end
`endif
          S_IDLE, S_IGNORE: begin
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged open-drain master plus a small core model answering MISO_REQ.
// The clock-stretch scenario is compiled in only when I2C_SLAVE_STRETCH_EN is defined.
module tb_i2c_slave_responder;

  localparam int Q = 8;
  localparam int H = 16;

  logic       SYS_CLOCK = 1'b0;
  logic       RST_N;
  wire        sdaBus;
  wire        sclBus;
  logic [7:0] MOSI;
  logic       MOSI_VALID;
  logic [7:0] MISO;
  logic       MISO_REQ;
  logic       MISO_VALID;
  logic       BUSY;
  logic       STOP_DET;

  logic mSdaLow = 1'b0;
  logic mSclLow = 1'b0;

  int assertCount = 0;
  int failCount   = 0;

  int mosiCount     = 0;
  int stopCount     = 0;
  int misoReqCount  = 0;
  int slaveLowCount = 0;
  int stretchCycles = 0;
  int busyCount     = 0;
  int respBase      = 0;
  logic [7:0] mosiLog   [0:15];
  logic [7:0] respBytes [0:3];

  pullup (sdaBus);
  pullup (sclBus);
  assign sdaBus = mSdaLow ? 1'b0 : 1'bz;
  assign sclBus = mSclLow ? 1'b0 : 1'bz;

  always #5 SYS_CLOCK = ~SYS_CLOCK;

  i2c_slave_responder dut (
    .SYS_CLOCK (SYS_CLOCK),
    .RST_N     (RST_N),
    .SDA       (sdaBus),
    .SCL       (sclBus),
    .MOSI      (MOSI),
    .MOSI_VALID(MOSI_VALID),
    .MISO      (MISO),
    .MISO_REQ  (MISO_REQ),
    .MISO_VALID(MISO_VALID),
    .BUSY      (BUSY),
    .STOP_DET  (STOP_DET)
  );

  // Core model and bus monitors, sampled 2 ns after each rising edge.
  always begin
    int idx;
    @(posedge SYS_CLOCK);
    #2;
    if (MOSI_VALID === 1'b1) begin
      mosiLog[mosiCount % 16] = MOSI;
      mosiCount++;
    end
    if (STOP_DET === 1'b1) stopCount++;
    if (MISO_REQ === 1'b1) begin
      idx = misoReqCount - respBase;
      MISO = (idx >= 0 && idx < 4) ? respBytes[idx] : 8'hEE;
      misoReqCount++;
    end
    if (!mSdaLow && sdaBus === 1'b0) slaveLowCount++;
    if (!mSclLow && sclBus === 1'b0) stretchCycles++;
    if (BUSY === 1'b1) busyCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitC(input int n);
    repeat (n) @(negedge SYS_CLOCK);
  endtask

  task automatic sclRelease();
    int waitCnt;
    mSclLow = 1'b0;
    waitCnt = 0;
    while (sclBus !== 1'b1 && waitCnt < 3000) begin
      @(negedge SYS_CLOCK);
      waitCnt++;
    end
    if (sclBus !== 1'b1) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scl_release_timeout: SCL=%b, required 1", sclBus);
    end
  endtask

  task automatic writeBit(input logic b);
    mSdaLow = ~b;
    waitC(Q);
    sclRelease();
    waitC(H);
    mSclLow = 1'b1;
    waitC(Q);
  endtask

  task automatic readBit(output logic b);
    mSdaLow = 1'b0;
    waitC(Q);
    sclRelease();
    waitC(H / 2);
    b = sdaBus;
    waitC(H / 2);
    mSclLow = 1'b1;
    waitC(Q);
  endtask

  task automatic i2cStart();
    mSdaLow = 1'b0;
    waitC(Q);
    sclRelease();
    waitC(Q);
    mSdaLow = 1'b1;
    waitC(Q);
    mSclLow = 1'b1;
    waitC(Q);
  endtask

  task automatic i2cStop();
    mSdaLow = 1'b1;
    waitC(Q);
    sclRelease();
    waitC(Q);
    mSdaLow = 1'b0;
    waitC(H);
  endtask

  task automatic writeByte(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(data[i]);
    readBit(ack);
  endtask

  task automatic readByte(input logic nack, output logic [7:0] data);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      readBit(b);
      data[i] = b;
    end
    writeBit(nack);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    waitC(3);
    assertCount++;
    if (BUSY !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b, expected 0", BUSY); end
    assertCount++;
    if (MOSI !== 8'h00) begin failCount++; $display("[TB] FAIL reset_mosi: got %h, expected 00", MOSI); end
    assertCount++;
    if (MOSI_VALID !== 1'b0) begin failCount++; $display("[TB] FAIL reset_mosi_valid: got %b, expected 0", MOSI_VALID); end
    assertCount++;
    if (MISO_REQ !== 1'b0) begin failCount++; $display("[TB] FAIL reset_miso_req: got %b, expected 0", MISO_REQ); end
    assertCount++;
    if (STOP_DET !== 1'b0) begin failCount++; $display("[TB] FAIL reset_stop_det: got %b, expected 0", STOP_DET); end
    assertCount++;
    if (sdaBus !== 1'b1) begin failCount++; $display("[TB] FAIL reset_sda: got %b, expected 1", sdaBus); end
    assertCount++;
    if (sclBus !== 1'b1) begin failCount++; $display("[TB] FAIL reset_scl: got %b, expected 1", sclBus); end
    RST_N = 1'b1;
    waitC(4);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int mosiBase, stopBase;
    $display("[TB] write 0x42: A5, 3C");
    mosiBase = mosiCount;
    stopBase = stopCount;
    i2cStart();
    writeByte(8'h84, a0);
    assertCount++;
    if (BUSY !== 1'b1) begin failCount++; $display("[TB] FAIL write_busy_after_addr: got %b, expected 1", BUSY); end
    writeByte(8'hA5, a1);
    writeByte(8'h3C, a2);
    i2cStop();
    waitC(4);
    assertCount++;
    if ({a0, a1, a2} !== 3'b000) begin failCount++; $display("[TB] FAIL write_acks: got %b, expected 000", {a0, a1, a2}); end
    assertCount++;
    if (mosiCount - mosiBase !== 2) begin failCount++; $display("[TB] FAIL write_mosi_valid_count: got %0d, expected 2", mosiCount - mosiBase); end
    assertCount++;
    if (mosiLog[mosiBase % 16] !== 8'hA5) begin failCount++; $display("[TB] FAIL write_byte0: got %h, expected a5", mosiLog[mosiBase % 16]); end
    assertCount++;
    if (mosiLog[(mosiBase + 1) % 16] !== 8'h3C) begin failCount++; $display("[TB] FAIL write_byte1: got %h, expected 3c", mosiLog[(mosiBase + 1) % 16]); end
    assertCount++;
    if (MOSI !== 8'h3C) begin failCount++; $display("[TB] FAIL write_mosi_final: got %h, expected 3c", MOSI); end
    assertCount++;
    if (stopCount - stopBase !== 1) begin failCount++; $display("[TB] FAIL write_stop_det: got %0d, expected 1", stopCount - stopBase); end
    assertCount++;
    if (BUSY !== 1'b0) begin failCount++; $display("[TB] FAIL write_busy_after_stop: got %b, expected 0", BUSY); end
  endtask

  task automatic test_wrong_address();
    logic a0, a1;
    int mosiBase, lowBase, busyBase;
    $display("[TB] write to 0x17 (not ours)");
    mosiBase = mosiCount;
    lowBase  = slaveLowCount;
    busyBase = busyCount;
    i2cStart();
    writeByte(8'h2E, a0);
    writeByte(8'h55, a1);
    i2cStop();
    waitC(4);
    assertCount++;
    if (a0 !== 1'b1) begin failCount++; $display("[TB] FAIL wrong_addr_nack: got %b, expected 1", a0); end
    assertCount++;
    if (a1 !== 1'b1) begin failCount++; $display("[TB] FAIL wrong_addr_data_nack: got %b, expected 1", a1); end
    assertCount++;
    if (mosiCount - mosiBase !== 0) begin failCount++; $display("[TB] FAIL wrong_addr_mosi_valid: got %0d, expected 0", mosiCount - mosiBase); end
    assertCount++;
    if (slaveLowCount - lowBase !== 0) begin failCount++; $display("[TB] FAIL wrong_addr_sda_driven: got %0d cycles, expected 0", slaveLowCount - lowBase); end
    assertCount++;
    if (busyCount - busyBase !== 0) begin failCount++; $display("[TB] FAIL wrong_addr_busy: got %0d cycles, expected 0", busyCount - busyBase); end
  endtask

  task automatic test_read();
    logic a0;
    logic [7:0] d0, d1;
    int reqBase, stopBase;
    $display("[TB] read 0x42: 96 (ACK), 0F (NACK)");
    respBytes[0] = 8'h96;
    respBytes[1] = 8'h0F;
    respBase = misoReqCount;
    reqBase  = misoReqCount;
    stopBase = stopCount;
    i2cStart();
    writeByte(8'h85, a0);
    readByte(1'b0, d0);
    readByte(1'b1, d1);
    waitC(2);
    assertCount++;
    if (a0 !== 1'b0) begin failCount++; $display("[TB] FAIL read_addr_ack: got %b, expected 0", a0); end
    assertCount++;
    if (d0 !== 8'h96) begin failCount++; $display("[TB] FAIL read_byte0: got %h, expected 96", d0); end
    assertCount++;
    if (d1 !== 8'h0F) begin failCount++; $display("[TB] FAIL read_byte1: got %h, expected 0f", d1); end
    assertCount++;
    if (misoReqCount - reqBase !== 2) begin failCount++; $display("[TB] FAIL read_miso_req_count: got %0d, expected 2", misoReqCount - reqBase); end
    assertCount++;
    if (BUSY !== 1'b1) begin failCount++; $display("[TB] FAIL read_busy_after_nack: got %b, expected 1", BUSY); end
    i2cStop();
    waitC(4);
    assertCount++;
    if (stopCount - stopBase !== 1) begin failCount++; $display("[TB] FAIL read_stop_det: got %0d, expected 1", stopCount - stopBase); end
    assertCount++;
    if (BUSY !== 1'b0) begin failCount++; $display("[TB] FAIL read_busy_after_stop: got %b, expected 0", BUSY); end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2;
    logic [7:0] d0;
    int stopBase;
    $display("[TB] write 11, repeated START, read C3");
    respBytes[0] = 8'hC3;
    respBase = misoReqCount;
    stopBase = stopCount;
    i2cStart();
    writeByte(8'h84, a0);
    writeByte(8'h11, a1);
    assertCount++;
    if (MOSI !== 8'h11) begin failCount++; $display("[TB] FAIL b2b_mosi: got %h, expected 11", MOSI); end
    i2cStart();
    writeByte(8'h85, a2);
    assertCount++;
    if (BUSY !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_busy: got %b, expected 1", BUSY); end
    readByte(1'b1, d0);
    assertCount++;
    if ({a0, a1, a2} !== 3'b000) begin failCount++; $display("[TB] FAIL b2b_acks: got %b, expected 000", {a0, a1, a2}); end
    assertCount++;
    if (d0 !== 8'hC3) begin failCount++; $display("[TB] FAIL b2b_read: got %h, expected c3", d0); end
    assertCount++;
    if (stopCount - stopBase !== 0) begin failCount++; $display("[TB] FAIL b2b_no_stop: got %0d, expected 0", stopCount - stopBase); end
    i2cStop();
    waitC(4);
    assertCount++;
    if (stopCount - stopBase !== 1) begin failCount++; $display("[TB] FAIL b2b_final_stop: got %0d, expected 1", stopCount - stopBase); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, b;
    $display("[TB] reset while driving a read bit low");
    respBytes[0] = 8'h00;
    respBase = misoReqCount;
    i2cStart();
    writeByte(8'h85, a0);
    for (int i = 0; i < 3; i++) readBit(b);
    assertCount++;
    if (sdaBus !== 1'b0) begin failCount++; $display("[TB] FAIL midread_sda_driven: got %b, expected 0", sdaBus); end
    RST_N = 1'b0;
    #1;
    assertCount++;
    if (sdaBus !== 1'b1) begin failCount++; $display("[TB] FAIL midread_sda_released: got %b, expected 1", sdaBus); end
    waitC(3);
    RST_N = 1'b1;
    waitC(4);
    i2cStart();
    writeByte(8'h84, a1);
    writeByte(8'h5A, a2);
    i2cStop();
    waitC(4);
    assertCount++;
    if ({a1, a2} !== 2'b00) begin failCount++; $display("[TB] FAIL post_reset_acks: got %b, expected 00", {a1, a2}); end
    assertCount++;
    if (MOSI !== 8'h5A) begin failCount++; $display("[TB] FAIL post_reset_mosi: got %h, expected 5a", MOSI); end
  endtask

`ifdef I2C_SLAVE_STRETCH_EN
  task automatic test_stretch();
    logic a0;
    logic [7:0] d0;
    int stretchBase;
    $display("[TB] read with clock stretching");
    respBytes[0] = 8'h7E;
    respBase = misoReqCount;
    MISO_VALID = 1'b0;
    i2cStart();
    writeByte(8'h85, a0);
    stretchBase = stretchCycles;
    fork
      readByte(1'b1, d0);
      begin
        int w;
        w = 0;
        while (!(!mSclLow && sclBus === 1'b0) && w < 2000) begin
          @(negedge SYS_CLOCK);
          w++;
        end
        repeat (500) @(negedge SYS_CLOCK);
        MISO_VALID = 1'b1;
      end
    join
    i2cStop();
    waitC(4);
    assertCount++;
    if (stretchCycles - stretchBase < 500 || stretchCycles - stretchBase > 510) begin
      failCount++;
      $display("[TB] FAIL stretch_cycles: got %0d, expected 500..510", stretchCycles - stretchBase);
    end
    assertCount++;
    if (d0 !== 8'h7E) begin failCount++; $display("[TB] FAIL stretch_read: got %h, expected 7e", d0); end
  endtask
`endif

  initial begin
    MISO       = 8'h00;
    MISO_VALID = 1'b1;
    RST_N      = 1'b0;
    test_reset();
    test_write();
    test_wrong_address();
    test_read();
    test_back_to_back();
    test_reset_mid_read();
`ifdef I2C_SLAVE_STRETCH_EN
    test_stretch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- I2C target (responder) for the on-board bus. It answers transfers from the I2C master controller used by the I2C connect wrapper.
- Decodes START/STOP, matches a 7-bit address, and handles write traffic: it receives bytes and ACKs each one.
- Handles read traffic: it shifts out bytes supplied by the core and samples the master's ACK/NACK.
- Exposes a simple byte-level valid/request interface to the RISC-V Otter MMIO side.

Parameters:
- DEVICE_ADDR, 7'h42, 7-bit address this block responds to.
- SYNC_STAGES, 2, synchronizer flops on SCL/SDA inputs (min 2).

Ports:
- SYS_CLOCK  input  1  system clock; all logic on posedge
- RST_N  input  1  asynchronous active-low reset
- SDA  inout  1  I2C data, open-drain (drive 0 or Z only)
- SCL  inout  1  I2C clock, open-drain (driven only under I2C_SLAVE_STRETCH_EN)
- MOSI  output  8  last byte written by master
- MOSI_VALID  output  1  1-cycle pulse, MOSI updated
- MISO  input  8  byte to return on read
- MISO_REQ  output  1  1-cycle pulse, core must present the next MISO byte
- MISO_VALID  input  1  core has MISO ready (used only with the stretch feature)
- BUSY  output  1  high from address match until STOP
- STOP_DET  output  1  1-cycle pulse on any STOP condition

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE; SDA and SCL released (Z).
  - MOSI=0, MOSI_VALID=0, MISO_REQ=0, BUSY=0, STOP_DET=0.
  - Reset mid-transfer releases the bus immediately.
- Input conditioning and events:
  - SCL/SDA pass through SYNC_STAGES flops, plus one history flop for edge detect.
  - Events are evaluated on the synchronized values.
  - START: SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1.
  - START or STOP overrides all states.
- Bit timing:
  - Sample SDA on the synchronized SCL rising edge.
  - Change the driven SDA on the cycle after the synchronized SCL falling edge.
- States:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits MSB first. After bit 8:
    - addr==DEVICE_ADDR -> ADDR_ACK.
    - Otherwise (including general call 0x00) -> IGNORE; no ACK, SDA stays Z.
  - ADDR_ACK:
    - On the SCL fall after bit 8, drive SDA=0 and set BUSY=1.
    - If RW=1, pulse MISO_REQ at the ACK-bit SCL rise.
    - On the next SCL fall, release SDA. Then RW=0 -> WR_DATA; RW=1 -> load MISO into the shift reg, drive its MSB, -> RD_DATA.
  - WR_DATA: shift 8 bits. At the bit-8 SCL rise, update MOSI and pulse MOSI_VALID -> WR_ACK.
  - WR_ACK: always ACK (no backpressure). Drive 0 for one SCL period -> WR_DATA.
  - RD_DATA:
    - Drive Z for a '1' bit, 0 for a '0' bit, updated on each SCL fall.
    - After the 8th SCL fall, release SDA -> RD_ACK.
  - RD_ACK: sample SDA at the SCL rise.
    - ACK(0): pulse MISO_REQ; on the next fall load MISO -> RD_DATA.
    - NACK(1) -> IGNORE.
  - IGNORE: SDA Z; wait for START (-> ADDR) or STOP (-> IDLE).
- STOP in any state -> IDLE, BUSY=0, release SDA, pulse STOP_DET.
- Repeated START in any state -> ADDR, BUSY stays as-is until the next address phase resolves.
- The block never drives SDA low while SCL is high, except when holding an ACK/data bit through the high phase.
- SDA toggling while SCL is high counts only as START/STOP, never as data.

Optional Feature:
- Macro: I2C_SLAVE_STRETCH_EN.
- Defined: in read flow, after the SCL fall that would load MISO, hold SCL low until MISO_VALID=1, then load MISO and release SCL next cycle. STOP/START/reset still release SCL.
- Undefined: SCL is never driven (always Z), MISO_VALID is ignored, and MISO is loaded unconditionally on that fall.

Test Plan:
- Write 0x42 (W) then data 0xA5, 0x3C, STOP, via i2c_master with divider 16'h007D -> ACK on all 3 bytes; MOSI_VALID pulses twice; MOSI=0xA5 then 0x3C; STOP_DET pulses once; BUSY low after STOP.
- Address 0x17 (W) + 0x55 -> NACK on address; no MOSI_VALID; SDA never driven; BUSY stays 0.
- Read from 0x42, core returns 0x96 then 0x0F, master ACKs byte 1 and NACKs byte 2 -> master receives 0x96, 0x0F; MISO_REQ pulses exactly twice; state IGNORE then IDLE at STOP.
- Write 0x42 + 0x11, repeated START, read 0x42 returning 0xC3 -> MOSI=0x11; read returns 0xC3 without an intervening STOP_DET.
- Assert RST_N=0 mid read byte (bit 4 driving 0) -> SDA Z within 1 cycle of reset (async); after release, the next valid write to 0x42 is ACKed.
- With I2C_SLAVE_STRETCH_EN: read 0x42, MISO_VALID held 0 for 500 cycles -> SCL held low 500 cycles; after MISO_VALID=1 with MISO=0x7E, the master reads 0x7E.
